window_line_buffer: RTL and testbench

Streaming K×K window generator for the convolution datapath. It accepts raster-order pixels (1..CHANNELS channels) over a valid/ready handshake and holds kernel_size−1 previous image rows in line buffers. For every input position whose window lies fully inside the image, it emits one complete window. It replaces per-window SRAM re-fetching with single-pass streaming, supports runtime image and kernel size, and propagates backpressure from the convolution engine.

---
 rtl/window_line_buffer_pkg.sv | 10 +
 rtl/window_line_buffer_if.sv | 22 ++
 rtl/window_line_buffer_line_buffer.sv | 16 +
 rtl/window_line_buffer.sv | 123 ++++++++++++
 tb/tb_window_line_buffer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/window_line_buffer_pkg.sv
// window_line_buffer_pkg: shared state encoding, pixel type and config check
package window_line_buffer_pkg;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  localparam int DEF_PIXEL_DEPTH = 8;
  localparam int DEF_CHANNELS = 1;
  typedef logic [DEF_CHANNELS-1:0][DEF_PIXEL_DEPTH-1:0] pixel_t;
  function automatic logic cfg_ok(int w, int h, int k, int x_max, int y_max, int k_max);
    return k[0] && k >= 1 && k <= k_max && k <= w && k <= h && w <= x_max && h <= y_max;
  endfunction
endpackage

// File: rtl/window_line_buffer_if.sv
// window_line_buffer_if: pixel input and window output handshakes
interface window_line_buffer_if #(
  parameter int MAX_KERNEL = 7,
  parameter int X_MAX = 640,
  parameter int Y_MAX = 480,
  parameter int PIXEL_DEPTH = 8,
  parameter int CHANNELS = 1
);
  logic in_valid, in_ready, out_valid, out_ready, out_last;
  logic [CHANNELS-1:0][PIXEL_DEPTH-1:0] in_pixel;
  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][CHANNELS-1:0][PIXEL_DEPTH-1:0] out_window;
  logic [$clog2(X_MAX)-1:0] out_x;
  logic [$clog2(Y_MAX)-1:0] out_y;
  modport master (
    output in_valid, in_pixel, out_ready,
    input in_ready, out_valid, out_window, out_x, out_y, out_last
  );
  modport slave (
    input in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_window, out_x, out_y, out_last
  );
endinterface

// File: rtl/window_line_buffer_line_buffer.sv
// line_buffer: one image row of pixels with a read-before-write port
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout
);
  logic [WIDTH-1:0] mem [DEPTH];
  assign dout = mem[addr];
  // the old sample is read combinationally, the new one lands on the edge
  always_ff @(posedge clk) if (we) mem[addr] <= din;
endmodule

// File: rtl/window_line_buffer.sv
// window_line_buffer: streaming KxK window generator over chained line buffers
module window_line_buffer
  import window_line_buffer_pkg::*;
#(
  parameter int MAX_KERNEL = 7,
  parameter int X_MAX = 640,
  parameter int Y_MAX = 480,
  parameter int PIXEL_DEPTH = 8,
  parameter int CHANNELS = 1,
  localparam int XW = $clog2(X_MAX),
  localparam int YW = $clog2(Y_MAX)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          start,
  input  logic          new_trans,
  input  logic [XW:0]   img_width,
  input  logic [YW:0]   img_height,
  input  logic [7:0]    kernel_size,
  output logic          busy,
  output logic          cfg_err,
  window_line_buffer_if.slave bus
);
  typedef logic [CHANNELS-1:0][PIXEL_DEPTH-1:0] pix_t;
  typedef logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][CHANNELS-1:0][PIXEL_DEPTH-1:0] win_t;
  state_t state;
  logic [XW-1:0] x, out_x;
  logic [YW-1:0] y, out_y;
  logic [XW:0] w_r;
  logic [YW:0] h_r;
  logic [7:0] k_r;
  win_t win, nwin, out_window;
  logic out_valid, out_last, in_ready, accept, x_end, y_end, emit, cfg_legal;
  pix_t lb [MAX_KERNEL];

  assign in_ready = state == STREAM && (!out_valid || bus.out_ready);
  assign accept = bus.in_valid && in_ready && !new_trans;
  assign x_end = {1'b0, x} == w_r - (XW+1)'(1);
  assign y_end = {1'b0, y} == h_r - (YW+1)'(1);
  assign emit = 16'(x) + 16'd1 >= 16'(k_r) && 16'(y) + 16'd1 >= 16'(k_r);
  assign cfg_legal = cfg_ok(int'(img_width), int'(img_height), int'(kernel_size), X_MAX, Y_MAX, MAX_KERNEL);
  assign busy = state != IDLE;
  assign bus.in_ready = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_window = out_window;
  assign bus.out_x = out_x;
  assign bus.out_y = out_y;
  assign bus.out_last = out_last;

  // lb[0] is the incoming pixel, lb[i] is the pixel i rows above it
  assign lb[0] = bus.in_pixel;
  for (genvar i = 0; i < MAX_KERNEL - 1; i++) begin : g_lb
    line_buffer #(.DEPTH(X_MAX), .WIDTH(CHANNELS * PIXEL_DEPTH)) u_lb (
      .clk(clk), .we(accept), .addr(x), .din(lb[i]), .dout(lb[i+1])
    );
  end

  // shift the window one column left and insert the new column at K-1; columns past K stay zero
  always_comb begin
    nwin = '0;
    for (int c = 0; c < MAX_KERNEL; c++)
      for (int r = 0; r < MAX_KERNEL; r++)
        nwin[c][r] = c + 1 < int'(k_r) ? win[c < MAX_KERNEL - 1 ? c + 1 : c][r]
                   : c + 1 == int'(k_r) && r < int'(k_r) ? lb[int'(k_r) - 1 - r] : '0;
  end

  // frame FSM, raster counters, window shift register and output register
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state <= IDLE;
      x <= '0;
      y <= '0;
      w_r <= '0;
      h_r <= '0;
      k_r <= '0;
      win <= '0;
      out_window <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      out_x <= '0;
      out_y <= '0;
      cfg_err <= 1'b0;
    end else if (new_trans) begin
      state <= IDLE;
      x <= '0;
      y <= '0;
      w_r <= '0;
      h_r <= '0;
      k_r <= '0;
      win <= '0;
      out_window <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      out_x <= '0;
      out_y <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= state == IDLE && start && !cfg_legal;
      if (state == IDLE && start && cfg_legal) begin
        state <= STREAM;
        w_r <= img_width;
        h_r <= img_height;
        k_r <= kernel_size;
        x <= '0;
        y <= '0;
      end
      if (bus.out_ready) out_valid <= 1'b0;
      if (accept) begin
        win <= nwin;
        x <= x_end ? '0 : x + XW'(1);
        if (x_end && !y_end) y <= y + YW'(1);
        if (x_end && y_end) state <= DRAIN;
        if (emit) begin
          out_valid <= 1'b1;
          out_window <= nwin;
          out_x <= XW'(16'(x) + 16'd1 - 16'(k_r));
          out_y <= YW'(16'(y) + 16'd1 - 16'(k_r));
          out_last <= x_end && y_end;
        end
      end
      if (state == DRAIN && out_valid && bus.out_ready && out_last) state <= IDLE;
    end
endmodule

// File: tb/tb_window_line_buffer.sv
// tb_window_line_buffer: scoreboard bench against a direct image-window model
module tb_window_line_buffer;
  localparam int MK = 7, XM = 16, YM = 16, PD = 8, CH = 3;
  typedef logic [CH-1:0][PD-1:0] pix_t;
  typedef logic [MK-1:0][MK-1:0][CH-1:0][PD-1:0] win_t;
  typedef struct {
    win_t win;
    int x;
    int y;
    bit last;
  } exp_t;

  logic clk = 0, n_rst = 0, start = 0, new_trans = 0;
  logic [4:0] img_width = 0, img_height = 0;
  logic [7:0] kernel_size = 0;
  logic busy, cfg_err;

  window_line_buffer_if #(.MAX_KERNEL(MK), .X_MAX(XM), .Y_MAX(YM), .PIXEL_DEPTH(PD), .CHANNELS(CH)) bus();

  window_line_buffer #(.MAX_KERNEL(MK), .X_MAX(XM), .Y_MAX(YM), .PIXEL_DEPTH(PD), .CHANNELS(CH)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .new_trans(new_trans),
    .img_width(img_width), .img_height(img_height), .kernel_size(kernel_size),
    .busy(busy), .cfg_err(cfg_err), .bus(bus)
  );

  always #5 clk = ~clk;

  pix_t img [YM][XM];
  exp_t exp_q[$];
  int rd = 0, stall_at = -1, done_at = -1, stall_cnt = 0;
  int n_checks = 0, n_fail = 0;
  bit bp = 0;

  function automatic void chk(string nm, longint act, longint want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, want);
    end
  endfunction

  function automatic void chk_win(string nm, win_t act, win_t want);
    bit shown = 0;
    n_checks++;
    if (act !== want) begin
      n_fail++;
      for (int c = 0; c < MK; c++)
        for (int r = 0; r < MK; r++)
          for (int h = 0; h < CH; h++)
            if (!shown && act[c][r][h] !== want[c][r][h]) begin
              shown = 1;
              $display("FAIL %s: [%0d][%0d][%0d] got %0d expected %0d", nm, c, r, h, act[c][r][h], want[c][r][h]);
            end
    end
  endfunction

  // monitor: compare every presented window with the model, consume on handshake
  always @(negedge clk) begin
    #2;
    if (n_rst && bus.out_valid) begin
      if (rd >= exp_q.size()) begin
        n_checks++;
        n_fail++;
        $display("FAIL extra_window: got window at (%0d,%0d) expected none", bus.out_x, bus.out_y);
      end else begin
        chk_win("window", bus.out_window, exp_q[rd].win);
        chk("out_x", longint'(bus.out_x), exp_q[rd].x);
        chk("out_y", longint'(bus.out_y), exp_q[rd].y);
        chk("out_last", longint'(bus.out_last), longint'(exp_q[rd].last));
        if (!bus.out_ready) chk("in_ready_stall", longint'(bus.in_ready), 0);
        else rd++;
      end
    end
  end

  // consumer: random or full readiness, with a 5-cycle stall after a chosen window
  always @(negedge clk) begin
    if (stall_at >= 0 && rd == stall_at && done_at != stall_at) begin
      stall_cnt = 5;
      done_at = stall_at;
    end
    if (stall_cnt > 0) begin
      bus.out_ready = 1'b0;
      stall_cnt--;
    end else bus.out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic fill(int w, int h, bit rnd);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        for (int c = 0; c < CH; c++)
          img[y][x][c] = rnd ? 8'($urandom) : 8'(10 * y + x + 50 * c);
  endtask

  task automatic push_exp(int w, int h, int k, int npix);
    exp_t e;
    for (int oy = 0; oy <= h - k; oy++)
      for (int ox = 0; ox <= w - k; ox++)
        if ((oy + k - 1) * w + ox + k - 1 < npix) begin
          e.win = '0;
          for (int c = 0; c < k; c++)
            for (int r = 0; r < k; r++)
              e.win[c][r] = img[oy + r][ox + c];
          e.x = ox;
          e.y = oy;
          e.last = ox == w - k && oy == h - k;
          exp_q.push_back(e);
        end
  endtask

  task automatic feed(int w, int h, int k, int npix, bit gaps, bit poke);
    int i = 0;
    int t = 0;
    @(negedge clk);
    img_width = 5'(w);
    img_height = 5'(h);
    kernel_size = 8'(k);
    start = 1;
    while (i < npix && t < 4000) begin
      @(negedge clk);
      start = poke && npix > 2 && i == npix / 2;
      if (start) begin
        kernel_size = 8'd1;
        img_width = 5'd3;
      end
      bus.in_valid = !gaps || $urandom_range(0, 3) != 0;
      bus.in_pixel = img[i / w][i % w];
      #1;
      if (bus.in_valid && bus.in_ready) i++;
      t++;
    end
    chk("pixels_accepted", i, npix);
  endtask

  task automatic finish_frame();
    int t = 0;
    @(negedge clk);
    bus.in_valid = 0;
    start = 0;
    while ((busy || rd < exp_q.size()) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    #3;
    chk("frame_busy_done", longint'(busy), 0);
    chk("windows_consumed", rd, exp_q.size());
  endtask

  task automatic run_frame(int w, int h, int k, bit rnd, bit gaps, bit poke, bit stall);
    fill(w, h, rnd);
    if (stall) stall_at = exp_q.size() + 2;
    push_exp(w, h, k, w * h);
    feed(w, h, k, w * h, gaps, poke);
    finish_frame();
  endtask

  task automatic check_reset_vals();
    chk("rst_in_ready", longint'(bus.in_ready), 0);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk_win("rst_window", bus.out_window, '0);
    chk("rst_out_x", longint'(bus.out_x), 0);
    chk("rst_out_y", longint'(bus.out_y), 0);
    chk("rst_out_last", longint'(bus.out_last), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_cfg_err", longint'(cfg_err), 0);
  endtask

  task automatic bad_start(int w, int h, int k);
    @(negedge clk);
    img_width = 5'(w);
    img_height = 5'(h);
    kernel_size = 8'(k);
    start = 1;
    @(negedge clk);
    start = 0;
    #1;
    chk("cfg_err_pulse", longint'(cfg_err), 1);
    chk("bad_start_busy", longint'(busy), 0);
    @(negedge clk);
    #1;
    chk("cfg_err_clear", longint'(cfg_err), 0);
  endtask

  initial begin
    bus.in_valid = 0;
    bus.in_pixel = '0;
    #12;
    check_reset_vals();
    @(negedge clk);
    n_rst = 1;
    fill(4, 4, 1);
    feed(4, 4, 3, 6, 0, 0);
    #2;
    n_rst = 0;
    #1;
    check_reset_vals();
    @(negedge clk);
    n_rst = 1;
    bus.in_valid = 0;
    run_frame(4, 4, 3, 1, 0, 0, 0);
    run_frame(5, 5, 3, 0, 0, 0, 0);
    run_frame(5, 5, 3, 0, 0, 0, 1);
    run_frame(3, 2, 1, 1, 0, 0, 0);
    run_frame(5, 5, 5, 1, 0, 0, 0);
    bad_start(5, 5, 4);
    bad_start(5, 5, 9);
    bad_start(4, 5, 5);
    fill(6, 6, 1);
    push_exp(6, 6, 3, 22);
    feed(6, 6, 3, 22, 0, 0);
    @(negedge clk);
    new_trans = 1;
    bus.in_pixel = img[3][4];
    @(negedge clk);
    new_trans = 0;
    bus.in_valid = 0;
    #3;
    chk("abort_busy", longint'(busy), 0);
    chk("abort_out_valid", longint'(bus.out_valid), 0);
    chk("abort_in_ready", longint'(bus.in_ready), 0);
    chk("abort_windows", rd, exp_q.size());
    run_frame(6, 6, 3, 1, 0, 0, 0);
    bp = 1;
    for (int n = 0; n < 6; n++) begin
      int k, w, h;
      k = 2 * $urandom_range(0, 3) + 1;
      w = $urandom_range(k, 16);
      h = $urandom_range(k, 10);
      run_frame(w, h, k, 1, 1, n[0], 0);
    end
    bp = 0;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
